// File: rtl/data_mem_responder_if.sv
// MEM-stage data memory bus between the datapath (master)
// and the data memory responder (slave).
interface data_mem_responder_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_err;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout,
    input  mem_din, mem_stall, mem_err
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout,
    output mem_din, mem_stall, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM responder for the MEM stage,
// with optional wait states and stall/error signalling.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           ram [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  misal;
  logic                  oor;
  logic                  req;
  logic                  bad;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           wdata;
  logic [31:0]           din;
  logic                  stall;
  logic                  err;

  assign idx   = bus.mem_addr[ADDR_WIDTH+1:2];
  assign misal = |bus.mem_addr[1:0];
  assign oor   = |bus.mem_addr[31:ADDR_WIDTH+2];
  assign req   = bus.mem_ren | bus.mem_wen;
  assign bad   = misal | oor;

  // RAM has no reset; only the access control is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      ram[waddr] <= wdata;
    end
  end

  generate
    if (WAIT_STATES == 0) begin : g_comb
      always_comb begin
        we    = rst_n & bus.mem_wen & ~bad;
        waddr = idx;
        wdata = bus.mem_dout;
        stall = 1'b0;
        err   = req & bad;
        din   = '0;
        if (bus.mem_ren && !bus.mem_wen && !bad) begin
          din = ram[idx];
        end
      end
    end else begin : g_fsm
      typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
      } state_e;

      state_e                state_q, state_d;
      logic [3:0]            cnt_q, cnt_d;
      logic [ADDR_WIDTH-1:0] idx_q, idx_d;
      logic [31:0]           wdata_q, wdata_d;
      logic                  wr_q, wr_d;
      logic                  err_q, err_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          wdata_q <= '0;
          wr_q    <= 1'b0;
          err_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          idx_q   <= idx_d;
          wdata_q <= wdata_d;
          wr_q    <= wr_d;
          err_q   <= err_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        we      = 1'b0;
        waddr   = idx_q;
        wdata   = wdata_q;
        stall   = 1'b0;
        err     = 1'b0;
        din     = '0;
        unique case (state_q)
          S_IDLE: begin
            if (req) begin
              stall   = 1'b1;
              idx_d   = idx;
              wdata_d = bus.mem_dout;
              wr_d    = bus.mem_wen;
              err_d   = bad;
              cnt_d   = 4'(WAIT_STATES - 1);
              state_d = (WAIT_STATES == 1) ? S_DONE : S_WAIT;
            end
          end
          S_WAIT: begin
            // Inputs are ignored here; the latched copy drives DONE.
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_d == 4'd0) begin
              state_d = S_DONE;
            end
          end
          S_DONE: begin
            err     = err_q;
            we      = wr_q & ~err_q;
            state_d = S_IDLE;
            cnt_d   = '0;
            if (!wr_q && !err_q) begin
              din = ram[idx_q];
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  endgenerate

  assign bus.mem_din   = din;
  assign bus.mem_stall = stall;
  assign bus.mem_err   = err;

endmodule
